clk_rst_sequencer: RTL and testbench



---
 rtl/clkrst_pkg.sv | 14 +
 rtl/clk_en_div.sv | 26 ++
 rtl/clk_rst_sequencer.sv | 101 ++++++++++
 tb/tb_clk_rst_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/clkrst_pkg.sv
// clkrst_pkg: shared types and elaboration helpers for the clock/reset sequencer
package clkrst_pkg;
    typedef enum logic [2:0] {S_RST, S_WAIT_LOCK, S_STRETCH, S_RELEASE, S_RUN} state_t;
    function automatic int cnt_w(int a, int b);
        int m;
        m = a > b ? a : b;
        return m > 1 ? $clog2(m) : 1;
    endfunction
    function automatic int div_of(logic [63:0] list, int i, int w);
        logic [63:0] v;
        v = (list >> (i * w)) & ((64'd1 << w) - 64'd1);
        return int'(v[31:0]);
    endfunction
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: per-channel divider producing a one-cycle clock-enable while released
module clk_en_div #(
    parameter int DIV_W = 8,
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic run,
    output logic clk_en
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV > 1 ? DIV - 1 : 0);
    logic [DIV_W-1:0] c;
    logic run_q;
    // run is the next-cycle resetn; run_q mirrors the registered resetn so counting starts after release
    always_ff @(posedge CLK) begin
        if (RESET) begin
            c      <= '0;
            run_q  <= 1'b0;
            clk_en <= 1'b0;
        end else begin
            run_q  <= run;
            c      <= (run && run_q && c != LAST) ? c + DIV_W'(1) : '0;
            clk_en <= (DIV <= 1) ? run : (run && run_q && c == LAST);
        end
    end
endmodule

// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: staggered reset release after PLL lock with per-channel clock enables
module clk_rst_sequencer
    import clkrst_pkg::*;
#(
    parameter int NCH = 2,
    parameter int STRETCH = 16,
    parameter int STAGGER = 4,
    parameter int DIV_W = 8,
    parameter logic [NCH*DIV_W-1:0] DIV_LIST = {8'd4, 8'd1}
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           pll_locked,
    output logic [NCH-1:0] resetn,
    output logic [NCH-1:0] clk_en,
    output logic           ready
);
    localparam int CW = cnt_w(STRETCH, STAGGER);
    localparam int KW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] S_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] G_LAST = CW'(STAGGER - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [KW-1:0] k, k_d;
    logic [NCH-1:0] rn_d;
    logic ready_d;
    // sequencer state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_RST;
            cnt    <= '0;
            k      <= '0;
            resetn <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            k      <= k_d;
            resetn <= rn_d;
            ready  <= ready_d;
        end
    end
    // next state: stretch, then release channels in order; lock loss restarts from WAIT_LOCK
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        k_d     = k;
        rn_d    = resetn;
        ready_d = ready;
        case (state)
            S_RST: state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                state_d = pll_locked ? S_STRETCH : S_WAIT_LOCK;
                cnt_d   = '0;
            end
            S_STRETCH: begin
                if (cnt == S_LAST) begin
                    rn_d[0] = 1'b1;
                    cnt_d   = '0;
                    k_d     = KW'(1);
                    state_d = (NCH == 1) ? S_RUN : S_RELEASE;
                    ready_d = (NCH == 1);
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (cnt == G_LAST) begin
                    rn_d[k] = 1'b1;
                    cnt_d   = '0;
                    k_d     = (k == K_LAST) ? k : k + KW'(1);
                    state_d = (k == K_LAST) ? S_RUN : S_RELEASE;
                    ready_d = (k == K_LAST);
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RUN: state_d = S_RUN;
            default: state_d = S_RST;
        endcase
        if (!pll_locked && (state == S_STRETCH || state == S_RELEASE || state == S_RUN)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            k_d     = '0;
            rn_d    = '0;
            ready_d = 1'b0;
        end
    end
    for (genvar i = 0; i < NCH; i++) begin : g_div
        clk_en_div #(
            .DIV_W(DIV_W),
            .DIV  (div_of(64'(DIV_LIST), i, DIV_W))
        ) u_div (
            .CLK   (CLK),
            .RESET (RESET),
            .run   (rn_d[i]),
            .clk_en(clk_en[i])
        );
    end
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: directed and randomized checks against a timeline model
module tb_clk_rst_sequencer;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic pll_locked = 1'b1;
    logic [1:0] rn_a, en_a;
    logic rdy_a, rn_b, en_b, rdy_b;
    int compared = 0;
    int mismatched = 0;
    int mode = 0;
    int t = 0;
    int pulses;

    clk_rst_sequencer dut_a (
        .CLK(CLK), .RESET(RESET), .pll_locked(pll_locked),
        .resetn(rn_a), .clk_en(en_a), .ready(rdy_a)
    );

    clk_rst_sequencer #(.NCH(1), .STRETCH(1), .STAGGER(1), .DIV_W(8), .DIV_LIST(8'd0)) dut_b (
        .CLK(CLK), .RESET(RESET), .pll_locked(pll_locked),
        .resetn(rn_b), .clk_en(en_b), .ready(rdy_b)
    );

    always #5 CLK = ~CLK;

    // mode: 0 in reset, 1 waiting for lock, 2 sequencing with t edges since lock was seen
    function automatic logic [7:0] exp_rn(int md, int tt, int nch, int st, int sg);
        logic [7:0] e;
        e = '0;
        for (int j = 0; j < nch; j++) e[j] = (md == 2) && (tt >= st + j * sg);
        return e;
    endfunction

    function automatic logic [7:0] exp_en(int md, int tt, int nch, int st, int sg, logic [63:0] divs);
        logic [7:0] e;
        int tj, d, m;
        e = '0;
        for (int j = 0; j < nch; j++) begin
            tj = st + j * sg;
            d  = int'((divs >> (8 * j)) & 64'hff);
            m  = tt - tj;
            if (md == 2 && m >= 0) e[j] = (d <= 1) ? 1'b1 : (m > 0 && m % d == 0);
        end
        return e;
    endfunction

    function automatic logic exp_rdy(int md, int tt, int nch, int st, int sg);
        return (md == 2) && (tt >= st + (nch - 1) * sg);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l);
        RESET = r;
        pll_locked = l;
        @(posedge CLK);
        if (r) begin
            mode = 0;
            t = 0;
        end else if (mode == 0) begin
            mode = 1;
        end else if (mode == 1) begin
            if (l) begin
                mode = 2;
                t = 0;
            end
        end else if (!l) begin
            mode = 1;
        end else begin
            t++;
        end
        @(negedge CLK);
        chk("a.resetn", {6'b0, rn_a}, exp_rn(mode, t, 2, 16, 4));
        chk("a.clk_en", {6'b0, en_a}, exp_en(mode, t, 2, 16, 4, 64'h0401));
        chk("a.ready", {7'b0, rdy_a}, {7'b0, exp_rdy(mode, t, 2, 16, 4)});
        chk("b.resetn", {7'b0, rn_b}, exp_rn(mode, t, 1, 1, 1));
        chk("b.clk_en", {7'b0, en_b}, exp_en(mode, t, 1, 1, 1, 64'h0));
        chk("b.ready", {7'b0, rdy_b}, {7'b0, exp_rdy(mode, t, 1, 1, 1)});
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b1);
        pulses = 0;
        repeat (40) begin
            step(1'b0, 1'b1);
            pulses += int'(en_a[1]);
        end
        chk("a.pulses40", 8'(pulses), 8'd10);
        repeat (2) step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (11) step(1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (9) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (25) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b1);
        repeat (400) step($urandom_range(0, 59) == 0, $urandom_range(0, 24) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
